flag_condition_unit: RTL and testbench
======================================

Name: flag_condition_unit

Overview:
- Reader side of the 6-bit flag register: tracks outstanding flag writes (reservations), holds a branch until all older flag producers have written back, then evaluates a 4-bit condition code.
- Sits between the decode/issue stage (reserve, branch request), the flag write-back path and the fetch redirect logic.
- Returns a taken/not-taken result with the branch target over a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of the branch target.
- PEND_W, 2, width of the pending-write counter; maximum outstanding reservations is 2^PEND_W-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- flags_i  input  6  current flag register contents.
  - [0]=Z, [1]=C, [2]=S, [3]=V.
  - [5:4] are reserved and ignored.
- flag_wb_i  input  1  a flag write-back occurs this cycle
- flag_wb_data_i  input  6  flag value being written this cycle (bypass source)
- flag_reserve_i  input  1  an issued instruction will write the flags
- reserve_full_o  output  1  pending count is at its maximum
- pending_o  output  PEND_W  current pending-write count
- br_valid_i  input  1  branch request valid
- br_ready_o  output  1  unit can accept a branch
- br_cond_i  input  4  condition code
- br_target_i  input  ADDR_W  branch target
- res_valid_o  output  1  result valid
- res_ready_i  input  1  result consumer ready
- res_taken_o  output  1  condition true
- res_target_o  output  ADDR_W  latched target
- err_o  output  1  sticky protocol error

Behaviour:
- Reset (async) values:
  - state IDLE, pending_o=0, res_valid_o=0, res_taken_o=0, res_target_o=0, err_o=0.
  - br_ready_o=1, since it is 1 exactly in IDLE.
  - Reset mid-operation drops any held branch or result.
- Pending counter:
  - cnt_next = cnt + reserve - wb.
  - Reserve and wb in the same cycle leave the count unchanged.
  - Reserve while full with no wb: count holds, err_o set.
  - wb while cnt==0 with no reserve: count holds at 0, err_o set.
  - err_o clears only on reset.
  - reserve_full_o = (cnt == 2^PEND_W-1).
- Resolvable in a cycle iff cnt_next==0.
  - Flag source is flag_wb_data_i if flag_wb_i, else flags_i.
  - A reserve in the accept cycle, or while waiting, is treated as older than the branch, so the branch waits for it. This is conservative by design.
- FSM:
  - IDLE: br_ready_o=1. On br_valid_i, latch cond and target.
    - If resolvable: register res_taken_o and go to DONE (res_valid_o=1 the next cycle; 1-cycle latency).
    - Otherwise go to WAIT.
  - WAIT: br_ready_o=0. Each cycle, if resolvable, evaluate the latched cond against the flag source, register the result and go to DONE.
  - DONE: res_valid_o=1; res_taken_o and res_target_o are held stable. On res_ready_i, go to IDLE.
    - res_valid_o falls the next cycle.
    - br_ready_o stays 0 in DONE: no overlap, so a back-to-back branch is accepted at the earliest 1 cycle after the result handshake.
- Counter updates continue in every state.
- Condition codes:
  - 0 AL=1, 1 EQ=Z, 2 NE=!Z, 3 CS=C, 4 CC=!C, 5 MI=S, 6 PL=!S, 7 VS=V, 8 VC=!V.
  - 9 HI=C&!Z, A LS=!C|Z, B GE=(S==V), C LT=(S!=V), D GT=!Z&(S==V), E LE=Z|(S!=V), F NV=0.

Test Plan:
- Reset, cnt=0, flags_i=6'h01, branch cond=1 (EQ), target=32'h100 → res_valid_o=1 one cycle later, taken=1, target=32'h100; res_ready_i=1 → IDLE, br_ready_o=1 next cycle.
- Reserve twice (pending_o=2) then branch cond=2 (NE) → stays in WAIT. wb 6'h00 → still waiting. wb 6'h01 with bypass → taken=0 (NE with Z=1) one cycle after the second wb, without waiting for flags_i to update.
- Branch accepted in the same cycle as flag_reserve_i with cnt=0 → waits; resolves only after the matching wb.
- Hold res_ready_i=0 for 5 cycles in DONE, toggling flags_i → res_taken_o/res_target_o unchanged, br_ready_o=0 throughout.
- Sweep all 16 codes with flags Z/C/S/V in {0000,1111,0110,1001} → taken matches the table; AL always 1, NV always 0.
- Error and reset cases:
  - 3 reserves → reserve_full_o=1; a 4th → pending_o=3, err_o=1.
  - wb at cnt=0 → err_o stays 1.
  - Async rst asserted during WAIT → all outputs return to reset values immediately.

Source files
------------

// File: rtl/flag_condition_unit.sv
// Flag register reader: counts outstanding flag writes, stalls a branch until
// every older flag producer has written back, then evaluates its condition code.
module flag_condition_unit #(
  parameter int ADDR_W = 32,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        flags_i,
  input  logic              flag_wb_i,
  input  logic [5:0]        flag_wb_data_i,
  input  logic              flag_reserve_i,
  output logic              reserve_full_o,
  output logic [PEND_W-1:0] pending_o,
  input  logic              br_valid_i,
  output logic              br_ready_o,
  input  logic [3:0]        br_cond_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              res_taken_o,
  output logic [ADDR_W-1:0] res_target_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state, state_next;
  logic [PEND_W-1:0]   cnt, cnt_next;
  logic                err_set;
  logic [3:0]          cond_q, cond_next;
  logic [ADDR_W-1:0]   target_next;
  logic                taken_next;
  logic [3:0]          flag_src;
  logic                resolvable;
  logic                unused_flag_bits;

  assign unused_flag_bits = ^{flags_i[5:4], flag_wb_data_i[5:4]};

  // Flag bits: [0]=Z [1]=C [2]=S [3]=V
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic z, c, s, v;
    z = f[0];
    c = f[1];
    s = f[2];
    v = f[3];
    case (cc)
      4'h0:    cond_eval = 1'b1;
      4'h1:    cond_eval = z;
      4'h2:    cond_eval = !z;
      4'h3:    cond_eval = c;
      4'h4:    cond_eval = !c;
      4'h5:    cond_eval = s;
      4'h6:    cond_eval = !s;
      4'h7:    cond_eval = v;
      4'h8:    cond_eval = !v;
      4'h9:    cond_eval = c && !z;
      4'hA:    cond_eval = !c || z;
      4'hB:    cond_eval = (s == v);
      4'hC:    cond_eval = (s != v);
      4'hD:    cond_eval = !z && (s == v);
      4'hE:    cond_eval = z || (s != v);
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Illegal reserve/write-back leaves the count untouched and flags the error
  always_comb begin
    cnt_next = cnt;
    err_set  = 1'b0;
    case ({flag_reserve_i, flag_wb_i})
      2'b10: begin
        if (cnt == '1) err_set = 1'b1;
        else           cnt_next = cnt + PEND_W'(1);
      end
      2'b01: begin
        if (cnt == '0) err_set = 1'b1;
        else           cnt_next = cnt - PEND_W'(1);
      end
      default: cnt_next = cnt;
    endcase
  end

  assign flag_src   = flag_wb_i ? flag_wb_data_i[3:0] : flags_i[3:0];
  assign resolvable = (cnt_next == '0);

  always_comb begin
    state_next  = state;
    cond_next   = cond_q;
    target_next = res_target_o;
    taken_next  = res_taken_o;
    case (state)
      IDLE: begin
        if (br_valid_i) begin
          cond_next   = br_cond_i;
          target_next = br_target_i;
          if (resolvable) begin
            taken_next = cond_eval(br_cond_i, flag_src);
            state_next = DONE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (resolvable) begin
          taken_next = cond_eval(cond_q, flag_src);
          state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      err_o        <= 1'b0;
      cond_q       <= '0;
      res_target_o <= '0;
      res_taken_o  <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      err_o        <= err_o | err_set;
      cond_q       <= cond_next;
      res_target_o <= target_next;
      res_taken_o  <= taken_next;
    end
  end

  assign pending_o      = cnt;
  assign reserve_full_o = (cnt == '1);
  assign br_ready_o     = (state == IDLE);
  assign res_valid_o    = (state == DONE);

endmodule

// File: tb/tb_flag_condition_unit.sv
// Directed bench for flag_condition_unit: condition-code sweep table plus
// hand-written sequences for stalls, bypass, holding, errors and async reset.
module tb_flag_condition_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  flags_i;
  logic        flag_wb_i;
  logic [5:0]  flag_wb_data_i;
  logic        flag_reserve_i;
  logic        reserve_full_o;
  logic [1:0]  pending_o;
  logic        br_valid_i;
  logic        br_ready_o;
  logic [3:0]  br_cond_i;
  logic [31:0] br_target_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        res_taken_o;
  logic [31:0] res_target_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flag_condition_unit #(.ADDR_W(32), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .flags_i(flags_i), .flag_wb_i(flag_wb_i), .flag_wb_data_i(flag_wb_data_i),
    .flag_reserve_i(flag_reserve_i), .reserve_full_o(reserve_full_o),
    .pending_o(pending_o), .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
    .br_cond_i(br_cond_i), .br_target_i(br_target_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_taken_o(res_taken_o),
    .res_target_o(res_target_o), .err_o(err_o)
  );

  typedef struct {
    logic [5:0]  flags;     // applied flags_i
    logic [15:0] exp_mask;  // bit n = expected taken for condition code n
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic handshake();
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    check("post_hs_br_ready", 32'(br_ready_o), 1);
    check("post_hs_res_valid", 32'(res_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ZCSV 0000, 1111, 0110 (reserved bits set), 1001
    vecs[0] = '{6'h00, 16'h2D55};
    vecs[1] = '{6'h0F, 16'h4CAB};
    vecs[2] = '{6'h36, 16'h532D};
    vecs[3] = '{6'h09, 16'h54D3};

    rst = 1'b1; flags_i = '0; flag_wb_i = 0; flag_wb_data_i = '0; flag_reserve_i = 0;
    br_valid_i = 0; br_cond_i = '0; br_target_i = '0; res_ready_i = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_pending", 32'(pending_o), 0);
    check("rst_full", 32'(reserve_full_o), 0);
    check("rst_br_ready", 32'(br_ready_o), 1);
    check("rst_res_valid", 32'(res_valid_o), 0);
    check("rst_taken", 32'(res_taken_o), 0);
    check("rst_target", res_target_o, 0);
    check("rst_err", 32'(err_o), 0);

    // Immediate resolve: EQ with Z=1
    flags_i = 6'h01; br_valid_i = 1; br_cond_i = 4'h1; br_target_i = 32'h100;
    tick();
    br_valid_i = 0;
    check("eq_valid", 32'(res_valid_o), 1);
    check("eq_taken", 32'(res_taken_o), 1);
    check("eq_target", res_target_o, 32'h100);
    check("eq_br_ready", 32'(br_ready_o), 0);
    handshake();

    // Two reservations, NE branch, resolved through write-back bypass
    flags_i = 6'h00;
    flag_reserve_i = 1; tick(); tick(); flag_reserve_i = 0;
    check("res2_pending", 32'(pending_o), 2);
    br_valid_i = 1; br_cond_i = 4'h2; br_target_i = 32'h200;
    tick();
    br_valid_i = 0;
    check("ne_wait_valid", 32'(res_valid_o), 0);
    check("ne_wait_ready", 32'(br_ready_o), 0);
    flag_wb_i = 1; flag_wb_data_i = 6'h00;
    tick();
    flag_wb_i = 0;
    check("ne_wb1_pending", 32'(pending_o), 1);
    check("ne_wb1_valid", 32'(res_valid_o), 0);
    flag_wb_i = 1; flag_wb_data_i = 6'h01;
    tick();
    flag_wb_i = 0;
    check("ne_wb2_valid", 32'(res_valid_o), 1);
    check("ne_bypass_taken", 32'(res_taken_o), 0);
    check("ne_pending", 32'(pending_o), 0);

    // Hold DONE with consumer stalled while flags_i toggles
    for (int i = 0; i < 5; i++) begin
      flags_i = (i % 2 == 0) ? 6'h0F : 6'h00;
      tick();
      check("hold_valid", 32'(res_valid_o), 1);
      check("hold_taken", 32'(res_taken_o), 0);
      check("hold_target", res_target_o, 32'h200);
      check("hold_br_ready", 32'(br_ready_o), 0);
    end
    handshake();

    // Branch accepted together with a reserve: must wait for that write-back
    flags_i = 6'h01; flag_reserve_i = 1; br_valid_i = 1; br_cond_i = 4'h1; br_target_i = 32'h300;
    tick();
    flag_reserve_i = 0; br_valid_i = 0;
    check("same_res_valid", 32'(res_valid_o), 0);
    check("same_res_pending", 32'(pending_o), 1);
    tick(); tick();
    check("same_res_still_wait", 32'(res_valid_o), 0);
    flag_wb_i = 1; flag_wb_data_i = 6'h00;
    tick();
    flag_wb_i = 0;
    check("same_res_valid2", 32'(res_valid_o), 1);
    check("same_res_taken", 32'(res_taken_o), 0);
    check("same_res_target", res_target_o, 32'h300);
    handshake();

    // Condition-code sweep
    for (int v = 0; v < 4; v++) begin
      for (int cc = 0; cc < 16; cc++) begin
        flags_i = vecs[v].flags; br_valid_i = 1; br_cond_i = 4'(cc);
        br_target_i = 32'h1000 + 32'(v * 16 + cc);
        tick();
        br_valid_i = 0;
        check($sformatf("sweep_v%0d_cc%0h_valid", v, cc), 32'(res_valid_o), 1);
        check($sformatf("sweep_v%0d_cc%0h_taken", v, cc), 32'(res_taken_o),
              32'(vecs[v].exp_mask[cc]));
        check($sformatf("sweep_v%0d_cc%0h_target", v, cc), res_target_o,
              32'h1000 + 32'(v * 16 + cc));
        res_ready_i = 1; tick(); res_ready_i = 0;
      end
    end

    // Overflow and underflow
    flag_reserve_i = 1; tick(); tick(); tick(); flag_reserve_i = 0;
    check("full_flag", 32'(reserve_full_o), 1);
    check("full_pending", 32'(pending_o), 3);
    check("full_err_clear", 32'(err_o), 0);
    flag_reserve_i = 1; tick(); flag_reserve_i = 0;
    check("ovf_pending", 32'(pending_o), 3);
    check("ovf_err", 32'(err_o), 1);
    flag_wb_i = 1; tick(); tick(); tick(); flag_wb_i = 0;
    check("drain_pending", 32'(pending_o), 0);
    check("drain_full", 32'(reserve_full_o), 0);
    flag_wb_i = 1; tick(); flag_wb_i = 0;
    check("udf_pending", 32'(pending_o), 0);
    check("udf_err_sticky", 32'(err_o), 1);

    // Async reset while a branch waits
    flag_reserve_i = 1; tick(); flag_reserve_i = 0;
    br_valid_i = 1; br_cond_i = 4'h0; br_target_i = 32'h400;
    tick();
    br_valid_i = 0;
    check("wait_br_ready", 32'(br_ready_o), 0);
    check("wait_target", res_target_o, 32'h400);
    #2 rst = 1'b1;
    #1;
    check("arst_pending", 32'(pending_o), 0);
    check("arst_err", 32'(err_o), 0);
    check("arst_br_ready", 32'(br_ready_o), 1);
    check("arst_res_valid", 32'(res_valid_o), 0);
    check("arst_target", res_target_o, 0);
    check("arst_taken", 32'(res_taken_o), 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(res_valid_o), 0);
    check("post_rst_br_ready", 32'(br_ready_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
